// File: rtl/ram_program_loader_if.sv
// rtl/ram_program_loader_if.sv - RAM write-port bundle between the program loader and the CPU RAM
interface ram_program_loader_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we_n;

  modport master (output ram_addr, ram_data, ram_we_n);
  modport slave  (input  ram_addr, ram_data, ram_we_n);
endinterface

// File: rtl/ram_program_loader.sv
// rtl/ram_program_loader.sv - loads a program image into CPU RAM from strobed pins, then releases the CPU
module ram_program_loader #(
  parameter int RAM_BYTES   = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_mode,
  input  logic [7:0]            data_in,
  input  logic                  data_strobe,
  ram_program_loader_if.master  ram,
  output logic                  ack,
  output logic                  busy,
  output logic                  run,
  output logic [ADDR_W:0]       byte_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WRITE   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] ls_sync, ss_sync;
  logic                   ls, ss, ls_q, ss_q;
  logic                   ls_rise, ss_rise;
  logic [ADDR_W-1:0]      addr_q, addr_nx;
  logic [7:0]             data_q, data_nx;
  logic                   we_n_q, we_n_nx;
  logic                   ack_nx, run_nx;
  logic [ADDR_W:0]        cnt_nx;

  assign ls      = ls_sync[SYNC_STAGES-1];
  assign ss      = ss_sync[SYNC_STAGES-1];
  assign ls_rise = ls & ~ls_q;
  assign ss_rise = ss & ~ss_q;

  // Both pins cross into clk through equal-depth chains so their relative timing is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_sync <= '0;
      ss_sync <= '0;
      ls_q    <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], load_mode};
      ss_sync <= {ss_sync[SYNC_STAGES-2:0], data_strobe};
      ls_q    <= ls;
      ss_q    <= ss;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      we_n_q     <= 1'b1;
      ack        <= 1'b0;
      run        <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_nx;
      addr_q     <= addr_nx;
      data_q     <= data_nx;
      we_n_q     <= we_n_nx;
      ack        <= ack_nx;
      run        <= run_nx;
      byte_count <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr_q;
    data_nx  = data_q;
    ack_nx   = ack & ss;
    cnt_nx   = byte_count;
    case (state)
      IDLE: begin
        if (ls) begin
          state_nx = LOAD;
          addr_nx  = '0;
          cnt_nx   = '0;
        end
      end
      LOAD: begin
        // Losing load_mode wins over a coincident strobe edge.
        if (!ls) begin
          state_nx = DONE;
        end else if (ss_rise) begin
          data_nx  = data_in;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        ack_nx = 1'b1;
        cnt_nx = byte_count + {{ADDR_W{1'b0}}, 1'b1};
        if (addr_q == LAST_ADDR) begin
          state_nx = DONE;
        end else begin
          addr_nx  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        if (!ss) begin
          ack_nx   = 1'b0;
          state_nx = ls ? LOAD : DONE;
        end
      end
      DONE: begin
        if (ls_rise) begin
          state_nx = LOAD;
          addr_nx  = '0;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    we_n_nx = (state_nx != WRITE);
    run_nx  = (state == DONE) && (state_nx == DONE);
  end

  assign busy         = (state == LOAD) || (state == WRITE) || (state == RELEASE);
  assign ram.ram_addr = addr_q;
  assign ram.ram_data = data_q;
  assign ram.ram_we_n = we_n_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// tb/tb_ram_program_loader.sv - self-checking bench for ram_program_loader
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_mode = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_strobe = 1'b0;
  logic       ack, busy, run;
  logic [4:0] byte_count;

  ram_program_loader_if #(.ADDR_W(4)) ram_bus ();

  ram_program_loader #(.RAM_BYTES(16), .ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_mode   (load_mode),
    .data_in     (data_in),
    .data_strobe (data_strobe),
    .ram         (ram_bus.master),
    .ack         (ack),
    .busy        (busy),
    .run         (run),
    .byte_count  (byte_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Observed RAM writes, {addr, data}, captured mid-cycle.
  logic [11:0] got[$];
  logic        prev_low = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_low = 1'b0;
    end else begin
      if (!ram_bus.ram_we_n) begin
        chk("we_single_cycle", {31'd0, prev_low}, 32'd0);
        got.push_back({ram_bus.ram_addr, ram_bus.ram_data});
      end
      prev_low = !ram_bus.ram_we_n;
    end
  end

  // Reference model: image loading as a list of expected writes.
  logic [11:0] exp_q[$];
  int          m_cnt;
  bit          m_full;

  task automatic model_reset();
    exp_q.delete();
    got.delete();
    m_cnt  = 0;
    m_full = 0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    logic [31:0] a;
    if (!m_full) begin
      a = m_cnt;
      exp_q.push_back({a[3:0], d});
      m_cnt++;
      if (m_cnt == 16) m_full = 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    load_mode   = 1'b0;
    data_strobe = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int hi, lo;
    hi = $urandom_range(4, 7);
    lo = $urandom_range(3, 6);
    @(posedge clk);
    #1 data_in = d;
    @(posedge clk);
    #1 data_strobe = 1'b1;
    repeat (hi) @(posedge clk);
    #1 data_strobe = 1'b0;
    repeat (lo) @(posedge clk);
    #1;
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwrites"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_write%0d", tag, i), {20'd0, got[i]}, {20'd0, exp_q[i]});
  endtask

  typedef struct {
    int n_bytes;
    bit drop_mode;
    int dmode;       // 0 random data, 1 0x10+i, 2 A5/5A/FF
    int exp_writes;
    bit exp_run;
    int exp_count;
    bit exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] d;
    logic [7:0] fixed3[3];
    fixed3[0] = 8'hA5; fixed3[1] = 8'h5A; fixed3[2] = 8'hFF;

    vecs[0] = '{16, 1'b0, 1, 16, 1'b1, 16, 1'b0};
    vecs[1] = '{17, 1'b0, 0, 16, 1'b1, 16, 1'b0};
    vecs[2] = '{3,  1'b1, 2, 3,  1'b1, 3,  1'b0};
    vecs[3] = '{0,  1'b1, 0, 0,  1'b1, 0,  1'b0};
    vecs[4] = '{7,  1'b0, 0, 7,  1'b0, 7,  1'b1};
    vecs[5] = '{16, 1'b1, 0, 16, 1'b1, 16, 1'b0};

    // Reset with random pins.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 load_mode = 1'($urandom); data_strobe = 1'($urandom); data_in = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_we_n", ram_bus.ram_we_n, 1);
    chk("rst_run", run, 0);
    chk("rst_addr", ram_bus.ram_addr, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    load_mode = 1'b0; data_strobe = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle(5);
    chk("idle_busy", busy, 0);
    chk("idle_run", run, 0);

    // Table-driven image loads with model-predicted writes.
    foreach (vecs[v]) begin
      do_reset();
      model_reset();
      load_mode = 1'b1;
      idle(4);
      for (int i = 0; i < vecs[v].n_bytes; i++) begin
        case (vecs[v].dmode)
          1:       d = 8'h10 + 8'(i);
          2:       d = fixed3[i];
          default: d = 8'($urandom);
        endcase
        model_byte(d);
        send_byte(d);
      end
      if (vecs[v].drop_mode) load_mode = 1'b0;
      idle(6);
      cmp_writes($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_nwr_table", v), got.size(), vecs[v].exp_writes);
      chk($sformatf("vec%0d_run", v), run, {31'd0, vecs[v].exp_run});
      chk($sformatf("vec%0d_count", v), byte_count, vecs[v].exp_count);
      chk($sformatf("vec%0d_busy", v), busy, {31'd0, vecs[v].exp_busy});
    end

    // Latency: edge k is the first edge sampling the strobe high.
    do_reset();
    model_reset();
    load_mode = 1'b1;
    data_in = 8'h3C;
    idle(4);
    #1 data_strobe = 1'b1;
    @(posedge clk);               // k
    @(posedge clk);               // k+1
    @(negedge clk);
    chk("lat_we_k1", ram_bus.ram_we_n, 1);
    @(posedge clk);               // k+2
    @(negedge clk);
    chk("lat_we_k2", ram_bus.ram_we_n, 0);
    chk("lat_data_k2", ram_bus.ram_data, 8'h3C);
    chk("lat_addr_k2", ram_bus.ram_addr, 0);
    chk("lat_ack_k2", ack, 0);
    @(posedge clk);               // k+3
    @(negedge clk);
    chk("lat_we_k3", ram_bus.ram_we_n, 1);
    chk("lat_ack_k3", ack, 1);
    chk("lat_count_k3", byte_count, 1);
    chk("lat_addr_k3", ram_bus.ram_addr, 1);
    @(posedge clk);               // k+4
    #1 data_strobe = 1'b0;
    @(posedge clk);               // j: first edge sampling low
    @(posedge clk);               // j+1
    @(negedge clk);
    chk("lat_ack_j1", ack, 1);
    @(posedge clk);               // j+2
    @(negedge clk);
    chk("lat_ack_j2", ack, 0);
    chk("lat_nwrites", got.size(), 1);

    // Strobe edge coincident with load_mode falling, then restart.
    do_reset();
    model_reset();
    load_mode = 1'b1;
    idle(4);
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      model_byte(d);
      send_byte(d);
    end
    load_mode = 1'b0;
    data_strobe = 1'b1;
    idle(6);
    cmp_writes("coinc");
    chk("coinc_run", run, 1);
    chk("coinc_count", byte_count, 2);
    data_strobe = 1'b0;
    idle(4);
    load_mode = 1'b1;
    idle(4);
    chk("restart_run", run, 0);
    chk("restart_busy", busy, 1);
    chk("restart_addr", ram_bus.ram_addr, 0);
    chk("restart_count", byte_count, 0);
    m_cnt = 0;
    d = 8'($urandom);
    model_byte(d);
    send_byte(d);
    idle(2);
    cmp_writes("restart");

    // Reset asserted while a write is in flight.
    do_reset();
    model_reset();
    load_mode = 1'b1;
    data_in = 8'h77;
    idle(4);
    #1 data_strobe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rstw_we_low", ram_bus.ram_we_n, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_we_async", ram_bus.ram_we_n, 1);
    data_strobe = 1'b0;
    load_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    chk("rstw_count", byte_count, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_run", run, 0);
    chk("rstw_addr", ram_bus.ram_addr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
